// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: sequences one instruction over 3-5 states,
// with memory wait-state handshake, bounded wait timeout and illegal-opcode flag.
module multicycle_control #(
    parameter int OP_W       = 6,
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            mem_ready,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            MemtoReg,
    output logic            RegDst,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic [1:0]      PCSrc,
    output logic            illegal_op,
    output logic            mem_timeout,
    output logic [3:0]      state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        OPC_RTYPE   = 3'd0,
        OPC_LW      = 3'd1,
        OPC_SW      = 3'd2,
        OPC_BEQ     = 3'd3,
        OPC_J       = 3'd4,
        OPC_ADDI    = 3'd5,
        OPC_ILLEGAL = 3'd6
    } op_class_t;

    // Full-width compare, so any nonzero bit above the 6-bit field is illegal.
    function automatic op_class_t classify(input logic [OP_W-1:0] op);
        if (op == OP_W'(6'b000000)) begin
            return OPC_RTYPE;
        end else if (op == OP_W'(6'b100011)) begin
            return OPC_LW;
        end else if (op == OP_W'(6'b101011)) begin
            return OPC_SW;
        end else if (op == OP_W'(6'b000100)) begin
            return OPC_BEQ;
        end else if (op == OP_W'(6'b000010)) begin
            return OPC_J;
        end else if (op == OP_W'(6'b001000)) begin
            return OPC_ADDI;
        end else begin
            return OPC_ILLEGAL;
        end
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   wait_cnt_r;
    logic [CNT_W-1:0]   wait_cnt_next_s;
    logic               is_sw_r;
    logic               is_sw_next_s;
    logic               illegal_op_r;
    logic               mem_timeout_r;
    logic               illegal_s;
    logic               timeout_s;
    logic               in_mem_s;
    logic               at_limit_s;

    logic               pc_write_s;
    logic               pc_write_cond_s;
    logic               iord_s;
    logic               mem_read_s;
    logic               mem_write_s;
    logic               ir_write_s;
    logic               mem_to_reg_s;
    logic               reg_dst_s;
    logic               reg_write_s;
    logic               alu_src_a_s;
    logic [1:0]         alu_src_b_s;
    logic [1:0]         alu_op_s;
    logic [1:0]         pc_src_s;

    // The limit cycle is the WAIT_LIMIT-th consecutive cycle without mem_ready.
    assign at_limit_s = (wait_cnt_r == CNT_W'(WAIT_LIMIT - 1));

    // Next-state selection, wait timeout and illegal-opcode detection.
    always_comb begin
        state_next_s = state_r;
        is_sw_next_s = is_sw_r;
        illegal_s    = 1'b0;
        timeout_s    = 1'b0;
        in_mem_s     = 1'b0;
        case (state_r)
            S_FETCH: begin
                in_mem_s = 1'b1;
                if (mem_ready) begin
                    state_next_s = S_DECODE;
                end else if (at_limit_s) begin
                    timeout_s    = 1'b1;
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (classify(opcode))
                    OPC_RTYPE: state_next_s = S_EXEC;
                    OPC_LW: begin
                        state_next_s = S_MEMADR;
                        is_sw_next_s = 1'b0;
                    end
                    OPC_SW: begin
                        state_next_s = S_MEMADR;
                        is_sw_next_s = 1'b1;
                    end
                    OPC_BEQ:  state_next_s = S_BRANCH;
                    OPC_J:    state_next_s = S_JUMP;
                    OPC_ADDI: state_next_s = S_ADDIEX;
                    default: begin
                        illegal_s    = 1'b1;
                        state_next_s = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: state_next_s = is_sw_r ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                in_mem_s = 1'b1;
                if (mem_ready) begin
                    state_next_s = S_MEMWB;
                end else if (at_limit_s) begin
                    timeout_s    = 1'b1;
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_MEMRD;
                end
            end
            S_MEMWR: begin
                in_mem_s = 1'b1;
                if (mem_ready) begin
                    state_next_s = S_FETCH;
                end else if (at_limit_s) begin
                    timeout_s    = 1'b1;
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_MEMWR;
                end
            end
            S_MEMWB:  state_next_s = S_FETCH;
            S_EXEC:   state_next_s = S_ALUWB;
            S_ALUWB:  state_next_s = S_FETCH;
            S_BRANCH: state_next_s = S_FETCH;
            S_JUMP:   state_next_s = S_FETCH;
            S_ADDIEX: state_next_s = S_ADDIWB;
            S_ADDIWB: state_next_s = S_FETCH;
            default:  state_next_s = S_FETCH;
        endcase
    end

    // Wait counter restarts on every state change and after a timeout re-entry to FETCH.
    always_comb begin
        wait_cnt_next_s = wait_cnt_r;
        if (timeout_s || (state_next_s != state_r)) begin
            wait_cnt_next_s = {CNT_W{1'b0}};
        end else if (in_mem_s && !mem_ready) begin
            wait_cnt_next_s = wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_next_s = wait_cnt_r;
        end
    end

    // State, wait counter, lw/sw selector and one-cycle flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= S_FETCH;
            wait_cnt_r    <= {CNT_W{1'b0}};
            is_sw_r       <= 1'b0;
            illegal_op_r  <= 1'b0;
            mem_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            wait_cnt_r    <= wait_cnt_next_s;
            is_sw_r       <= is_sw_next_s;
            illegal_op_r  <= illegal_s;
            mem_timeout_r <= timeout_s;
        end
    end

    // Moore datapath controls; only the FETCH strobes look at mem_ready.
    always_comb begin
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        iord_s          = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        mem_to_reg_s    = 1'b0;
        reg_dst_s       = 1'b0;
        reg_write_s     = 1'b0;
        alu_src_a_s     = 1'b0;
        alu_src_b_s     = 2'b00;
        alu_op_s        = 2'b00;
        pc_src_s        = 2'b00;
        case (state_r)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                ir_write_s  = mem_ready;
                pc_write_s  = mem_ready;
            end
            S_DECODE: alu_src_b_s = 2'b11;
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                iord_s     = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
            end
            S_MEMWR: begin
                mem_write_s = 1'b1;
                iord_s      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'b10;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s     = 1'b1;
                alu_op_s        = 2'b01;
                pc_write_cond_s = 1'b1;
                pc_src_s        = 2'b01;
            end
            S_JUMP: begin
                pc_write_s = 1'b1;
                pc_src_s   = 2'b10;
            end
            S_ADDIEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_ADDIWB: reg_write_s = 1'b1;
            default: begin
                pc_write_s = 1'b0;
            end
        endcase
    end

    assign PCWrite     = pc_write_s      & ~reset;
    assign PCWriteCond = pc_write_cond_s & ~reset;
    assign IorD        = iord_s          & ~reset;
    assign MemRead     = mem_read_s      & ~reset;
    assign MemWrite    = mem_write_s     & ~reset;
    assign IRWrite     = ir_write_s      & ~reset;
    assign MemtoReg    = mem_to_reg_s    & ~reset;
    assign RegDst      = reg_dst_s       & ~reset;
    assign RegWrite    = reg_write_s     & ~reset;
    assign ALUSrcA     = alu_src_a_s     & ~reset;
    assign ALUSrcB     = reset ? 2'b00 : alu_src_b_s;
    assign ALUOp       = reset ? 2'b00 : alu_op_s;
    assign PCSrc       = reset ? 2'b00 : pc_src_s;
    assign illegal_op  = illegal_op_r    & ~reset;
    assign mem_timeout = mem_timeout_r   & ~reset;
    assign state       = reset ? 4'd0 : state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control words go
// through a scoreboard queue and are checked against the DUT at the negedge.
module tb_multicycle_control;

    localparam int OP_W = 6;

    logic            clk;
    logic            reset;
    logic [OP_W-1:0] opcode;
    logic            mem_ready;
    logic            PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic            MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]      ALUSrcB, ALUOp, PCSrc;
    logic            illegal_op, mem_timeout;
    logic [3:0]      state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  st;
        logic [17:0] ctl;
        string       tag;
    } exp_t;

    exp_t sb_q[$];

    multicycle_control #(.OP_W(OP_W), .WAIT_LIMIT(15), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word from the state table:
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,
    //  ALUSrcA,ALUSrcB,ALUOp,PCSrc,illegal_op,mem_timeout}
    function automatic logic [17:0] model(input logic [3:0] st, input logic mr,
                                          input logic ill, input logic tmo, input logic rs);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = 10'b0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            4'd0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1'b1; asb = 2'b10; end
            4'd3:  begin mrd = 1'b1; iord = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; end
            4'd5:  begin mwr = 1'b1; iord = 1'b1; end
            4'd6:  begin asa = 1'b1; aop = 2'b10; end
            4'd7:  begin rw = 1'b1; rdst = 1'b1; end
            4'd8:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
            4'd9:  begin pcw = 1'b1; pcs = 2'b10; end
            4'd10: begin asa = 1'b1; asb = 2'b10; end
            4'd11: rw = 1'b1;
            default: pcw = 1'b0;
        endcase
        if (rs) return 18'd0;
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill, tmo};
    endfunction

    // One cycle: drive at the negedge, push the expectation, check, advance.
    task automatic cyc(input logic rs, input logic mr, input logic [OP_W-1:0] op,
                       input logic [3:0] es, input logic ill, input logic tmo,
                       input string tag);
        exp_t e;
        exp_t got;
        logic [17:0] obs;
        reset = rs; mem_ready = mr; opcode = op;
        e.st = rs ? 4'd0 : es;
        e.ctl = model(es, mr, ill, tmo, rs);
        e.tag = tag;
        sb_q.push_back(e);
        #1;
        got = sb_q.pop_front();
        obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, illegal_op, mem_timeout};
        checks++;
        assert (state === got.st) else begin
            errors++;
            $error("FAIL %s state observed %0d expected %0d", got.tag, state, got.st);
        end
        checks++;
        assert (obs === got.ctl) else begin
            errors++;
            $error("FAIL %s ctl observed %b expected %b", got.tag, obs, got.ctl);
        end
        @(negedge clk);
    endtask

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_ADI = 6'b001000;
    localparam logic [5:0] OP_BAD = 6'b111111;

    initial begin
        reset = 1'b1; mem_ready = 1'b1; opcode = OP_R;
        @(negedge clk);
        // Reset held two cycles.
        cyc(1'b1, 1'b1, OP_R, 4'd0, 1'b0, 1'b0, "reset0");
        cyc(1'b1, 1'b1, OP_R, 4'd0, 1'b0, 1'b0, "reset1");
        // R-type: 0,1,6,7.
        cyc(1'b0, 1'b1, OP_R, 4'd0, 1'b0, 1'b0, "r_fetch");
        cyc(1'b0, 1'b1, OP_R, 4'd1, 1'b0, 1'b0, "r_decode");
        cyc(1'b0, 1'b1, OP_R, 4'd6, 1'b0, 1'b0, "r_exec");
        cyc(1'b0, 1'b1, OP_R, 4'd7, 1'b0, 1'b0, "r_aluwb");
        // lw: 0,1,2,3,4.
        cyc(1'b0, 1'b1, OP_LW, 4'd0, 1'b0, 1'b0, "lw_fetch");
        cyc(1'b0, 1'b1, OP_LW, 4'd1, 1'b0, 1'b0, "lw_decode");
        cyc(1'b0, 1'b1, OP_LW, 4'd2, 1'b0, 1'b0, "lw_memadr");
        cyc(1'b0, 1'b1, OP_LW, 4'd3, 1'b0, 1'b0, "lw_memrd");
        cyc(1'b0, 1'b1, OP_LW, 4'd4, 1'b0, 1'b0, "lw_memwb");
        // sw with three wait cycles: MemWrite held four cycles.
        cyc(1'b0, 1'b1, OP_SW, 4'd0, 1'b0, 1'b0, "sw_fetch");
        cyc(1'b0, 1'b1, OP_SW, 4'd1, 1'b0, 1'b0, "sw_decode");
        cyc(1'b0, 1'b1, OP_SW, 4'd2, 1'b0, 1'b0, "sw_memadr");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, OP_SW, 4'd5, 1'b0, 1'b0, "sw_wait");
        cyc(1'b0, 1'b1, OP_SW, 4'd5, 1'b0, 1'b0, "sw_done");
        // FETCH timeout after 15 idle cycles; IRWrite stays low throughout.
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, OP_BAD, 4'd0, 1'b0, 1'b0, "fetch_wait");
        cyc(1'b0, 1'b0, OP_BAD, 4'd0, 1'b0, 1'b1, "fetch_timeout");
        // Illegal opcode: pulse in the FETCH after DECODE.
        cyc(1'b0, 1'b1, OP_BAD, 4'd0, 1'b0, 1'b0, "ill_fetch");
        cyc(1'b0, 1'b1, OP_BAD, 4'd1, 1'b0, 1'b0, "ill_decode");
        cyc(1'b0, 1'b1, OP_BEQ, 4'd0, 1'b1, 1'b0, "ill_pulse");
        // beq then j then addi.
        cyc(1'b0, 1'b1, OP_BEQ, 4'd1, 1'b0, 1'b0, "beq_decode");
        cyc(1'b0, 1'b1, OP_BEQ, 4'd8, 1'b0, 1'b0, "beq_branch");
        cyc(1'b0, 1'b1, OP_J,   4'd0, 1'b0, 1'b0, "j_fetch");
        cyc(1'b0, 1'b1, OP_J,   4'd1, 1'b0, 1'b0, "j_decode");
        cyc(1'b0, 1'b1, OP_J,   4'd9, 1'b0, 1'b0, "j_jump");
        cyc(1'b0, 1'b1, OP_ADI, 4'd0, 1'b0, 1'b0, "addi_fetch");
        cyc(1'b0, 1'b1, OP_ADI, 4'd1, 1'b0, 1'b0, "addi_decode");
        cyc(1'b0, 1'b1, OP_ADI, 4'd10, 1'b0, 1'b0, "addi_ex");
        cyc(1'b0, 1'b1, OP_ADI, 4'd11, 1'b0, 1'b0, "addi_wb");
        // sw: mem_ready on the limit cycle wins, no timeout.
        cyc(1'b0, 1'b1, OP_SW, 4'd0, 1'b0, 1'b0, "swl_fetch");
        cyc(1'b0, 1'b1, OP_SW, 4'd1, 1'b0, 1'b0, "swl_decode");
        cyc(1'b0, 1'b1, OP_SW, 4'd2, 1'b0, 1'b0, "swl_memadr");
        for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, OP_SW, 4'd5, 1'b0, 1'b0, "swl_wait");
        cyc(1'b0, 1'b1, OP_SW, 4'd5, 1'b0, 1'b0, "swl_limit_ready");
        // lw: MEMRD timeout skips MEMWB.
        cyc(1'b0, 1'b1, OP_LW, 4'd0, 1'b0, 1'b0, "lwt_fetch");
        cyc(1'b0, 1'b1, OP_LW, 4'd1, 1'b0, 1'b0, "lwt_decode");
        cyc(1'b0, 1'b1, OP_LW, 4'd2, 1'b0, 1'b0, "lwt_memadr");
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, OP_LW, 4'd3, 1'b0, 1'b0, "lwt_wait");
        cyc(1'b0, 1'b1, OP_LW, 4'd0, 1'b0, 1'b1, "lwt_timeout");
        // Reset in MEMRD aborts the lw.
        cyc(1'b0, 1'b1, OP_LW, 4'd1, 1'b0, 1'b0, "rst_decode");
        cyc(1'b0, 1'b1, OP_LW, 4'd2, 1'b0, 1'b0, "rst_memadr");
        cyc(1'b1, 1'b1, OP_LW, 4'd3, 1'b0, 1'b0, "rst_in_memrd");
        cyc(1'b0, 1'b1, OP_LW, 4'd0, 1'b0, 1'b0, "rst_fetch");
        cyc(1'b0, 1'b1, OP_LW, 4'd1, 1'b0, 1'b0, "rst_decode2");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
